// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch, IR load, decode, then ALU/register/memory/PC strobes.
// Optional MEM_TIMEOUT_EN bounds memory handshakes and raises a sticky Fault.
module control_unit #(
  parameter int OPCODE_WIDTH   = 4,
  parameter int ALU_OP_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic                    Inst_Ready,
  input  logic                    Data_Ready,
  output logic                    Inst_Read,
  output logic                    IR_Load,
  output logic                    PC_Inc,
  output logic                    PC_Load,
  output logic [ALU_OP_WIDTH-1:0] Alu_Op,
  output logic                    Reg_Write,
  output logic [1:0]              Wb_Sel,
  output logic                    Data_Read,
  output logic                    Data_Write,
  output logic                    Illegal,
  output logic                    Halted,
  output logic                    Fault
);

  typedef enum logic [2:0] {
    S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_ST  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(15);

  // The wait counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t state, state_next;
  logic   is_alu;
  logic   timed_out;
  logic   fault_q;

  assign is_alu = (Opcode >= OP_ADD) && (Opcode <= OP_XOR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (Inst_Ready)     state_next = S_LOAD;
        else if (timed_out) state_next = S_HALT;
      end
      S_LOAD:   state_next = S_DECODE;
      S_DECODE: begin
        if (is_alu || Opcode == OP_LDI || Opcode == OP_JMP) state_next = S_EXEC;
        else if (Opcode == OP_LD || Opcode == OP_ST)        state_next = S_MEM;
        else if (Opcode == OP_HLT)                          state_next = S_HALT;
        else                                                state_next = S_FETCH;
      end
      S_EXEC: state_next = S_FETCH;
      S_MEM: begin
        if (Data_Ready)     state_next = (Opcode == OP_LD) ? S_WB : S_FETCH;
        else if (timed_out) state_next = S_HALT;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       ready;

  assign waiting   = (state == S_FETCH) || (state == S_MEM);
  assign ready     = (state == S_FETCH) ? Inst_Ready : Data_Ready;
  assign timed_out = waiting && !ready && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Any state change clears the count, which covers entry into FETCH and MEM.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt <= 8'd0;
      fault_q  <= 1'b0;
    end else begin
      if (state_next != state)      wait_cnt <= 8'd0;
      else if (waiting && !ready)   wait_cnt <= wait_cnt + 8'd1;
      if (timed_out)                fault_q  <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign fault_q   = 1'b0;
`endif

  // Moore outputs; Reset forces them all low in the cycle it is asserted.
  always_comb begin
    Inst_Read  = 1'b0;
    IR_Load    = 1'b0;
    PC_Inc     = 1'b0;
    PC_Load    = 1'b0;
    Alu_Op     = '0;
    Reg_Write  = 1'b0;
    Wb_Sel     = 2'd0;
    Data_Read  = 1'b0;
    Data_Write = 1'b0;
    Illegal    = 1'b0;
    Halted     = 1'b0;
    Fault      = fault_q && !Reset;
    if (!Reset) begin
      case (state)
        S_FETCH: Inst_Read = 1'b1;
        S_LOAD: begin
          IR_Load = 1'b1;
          PC_Inc  = 1'b1;
        end
        S_DECODE: Illegal = !(is_alu || Opcode inside {OP_NOP, OP_LDI, OP_LD,
                                                      OP_ST, OP_JMP, OP_HLT});
        S_EXEC: begin
          if (is_alu) begin
            Alu_Op    = ALU_OP_WIDTH'(Opcode - OP_ADD);
            Reg_Write = 1'b1;
          end else if (Opcode == OP_LDI) begin
            Reg_Write = 1'b1;
            Wb_Sel    = 2'd1;
          end else if (Opcode == OP_JMP) begin
            PC_Load   = 1'b1;
          end
        end
        S_MEM: begin
          Data_Read  = (Opcode == OP_LD);
          Data_Write = (Opcode == OP_ST);
        end
        S_WB: begin
          Reg_Write = 1'b1;
          Wb_Sel    = 2'd2;
        end
        S_HALT:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each driven cycle queues the expected
// output vector, and a monitor compares it against the DUT mid-cycle.
module tb_control_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Opcode = 4'd1;
  logic       Inst_Ready = 1'b1;
  logic       Data_Ready = 1'b0;
  logic       Inst_Read, IR_Load, PC_Inc, PC_Load, Reg_Write;
  logic       Data_Read, Data_Write, Illegal, Halted, Fault;
  logic [2:0] Alu_Op;
  logic [1:0] Wb_Sel;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode),
    .Inst_Ready(Inst_Ready), .Data_Ready(Data_Ready),
    .Inst_Read(Inst_Read), .IR_Load(IR_Load), .PC_Inc(PC_Inc), .PC_Load(PC_Load),
    .Alu_Op(Alu_Op), .Reg_Write(Reg_Write), .Wb_Sel(Wb_Sel),
    .Data_Read(Data_Read), .Data_Write(Data_Write),
    .Illegal(Illegal), .Halted(Halted), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // {Inst_Read, IR_Load, PC_Inc, PC_Load, Alu_Op[2:0], Reg_Write, Wb_Sel[1:0],
  //  Data_Read, Data_Write, Illegal, Halted, Fault}
  logic [14:0] obs;
  assign obs = {Inst_Read, IR_Load, PC_Inc, PC_Load, Alu_Op, Reg_Write, Wb_Sel,
                Data_Read, Data_Write, Illegal, Halted, Fault};

  localparam logic [14:0] V_IDLE  = 15'h0000;
  localparam logic [14:0] V_FETCH = 15'h4000;
  localparam logic [14:0] V_LOAD  = 15'h3000;
  localparam logic [14:0] V_JMP   = 15'h0800;
  localparam logic [14:0] V_RW    = 15'h0080;
  localparam logic [14:0] V_LDI   = 15'h00A0;
  localparam logic [14:0] V_WB    = 15'h00C0;
  localparam logic [14:0] V_RD    = 15'h0010;
  localparam logic [14:0] V_WR    = 15'h0008;
  localparam logic [14:0] V_ILL   = 15'h0004;
  localparam logic [14:0] V_HALT  = 15'h0002;
  localparam logic [14:0] V_FAULT = 15'h0001;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] v_alu(input logic [2:0] op);
    logic [14:0] r;
    r = V_RW;
    r[10:8] = op;
    return r;
  endfunction

  // Drive one cycle's inputs and queue the outputs expected during that cycle.
  task automatic cyc(input string tag, input logic rst, input logic ir,
                     input logic dr, input logic [3:0] op, input logic [14:0] e);
    exp_t x;
    @(negedge Clk);
    Reset      = rst;
    Inst_Ready = ir;
    Data_Ready = dr;
    Opcode     = op;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
  endtask

  // FETCH (ready at once), LOAD, DECODE for one instruction.
  task automatic head(input string tag, input logic [3:0] op, input logic dr);
    cyc({tag, "_fetch"},  1'b0, 1'b1, dr, op, V_FETCH);
    cyc({tag, "_load"},   1'b0, 1'b0, dr, op, V_LOAD);
    cyc({tag, "_decode"}, 1'b0, 1'b0, dr, op,
        (op >= 4'd10 && op <= 4'd14) ? V_ILL : V_IDLE);
  endtask

  always @(negedge Clk) begin
    #2;
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      check(cur.tag, 32'(obs), 32'(cur.v));
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 1'b1, 1'b0, 4'd1, V_IDLE);

    // ADD, then the remaining ALU ops, LDI and NOP back to back
    head("add", 4'd1, 1'b0);
    cyc("add_exec", 1'b0, 1'b0, 1'b0, 4'd1, v_alu(3'd0));
    for (int op = 2; op <= 5; op++) begin
      head("alu", 4'(op), 1'b0);
      cyc("alu_exec", 1'b0, 1'b0, 1'b0, 4'(op), v_alu(3'(op - 1)));
    end
    head("ldi", 4'd6, 1'b0);
    cyc("ldi_exec", 1'b0, 1'b0, 1'b0, 4'd6, V_LDI);
    head("nop", 4'd0, 1'b0);

    // Instruction fetch stalls until Inst_Ready
    for (int i = 0; i < 3; i++) cyc("fetch_wait", 1'b0, 1'b0, 1'b0, 4'd7, V_FETCH);

    // LD with Data_Ready arriving on the fourth MEM cycle
    head("ld", 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ld_wait", 1'b0, 1'b0, 1'b0, 4'd7, V_RD);
    cyc("ld_done", 1'b0, 1'b0, 1'b1, 4'd7, V_RD);
    cyc("ld_wb",   1'b0, 1'b0, 1'b0, 4'd7, V_WB);

    // LD with Data_Ready already high before MEM
    head("ld0", 4'd7, 1'b1);
    cyc("ld0_mem", 1'b0, 1'b0, 1'b1, 4'd7, V_RD);
    cyc("ld0_wb",  1'b0, 1'b0, 1'b0, 4'd7, V_WB);

    // ST then JMP
    head("st", 4'd8, 1'b0);
    for (int i = 0; i < 2; i++) cyc("st_wait", 1'b0, 1'b0, 1'b0, 4'd8, V_WR);
    cyc("st_done", 1'b0, 1'b0, 1'b1, 4'd8, V_WR);
    head("jmp", 4'd9, 1'b0);
    cyc("jmp_exec", 1'b0, 1'b0, 1'b0, 4'd9, V_JMP);

    // Illegal opcodes act as NOP
    head("ill12", 4'd12, 1'b0);
    head("ill10", 4'd10, 1'b0);
    head("ill14", 4'd14, 1'b0);

    // Reset during a pending LD drops the request and skips write-back
    head("ldrst", 4'd7, 1'b0);
    cyc("ldrst_mem", 1'b0, 1'b0, 1'b0, 4'd7, V_RD);
    cyc("ldrst_rst", 1'b1, 1'b0, 1'b1, 4'd7, V_IDLE);
    cyc("ldrst_after", 1'b0, 1'b0, 1'b1, 4'd7, V_FETCH);

    // HLT holds until Reset regardless of Inst_Ready
    head("hlt", 4'd15, 1'b0);
    for (int i = 0; i < 20; i++) cyc("halted", 1'b0, 1'(i), 1'(i >> 1), 4'd15, V_HALT);
    cyc("hlt_rst", 1'b1, 1'b1, 1'b0, 4'd15, V_IDLE);

    // Instruction fetch that never completes
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) cyc("to_fetch", 1'b0, 1'b0, 1'b0, 4'd1, V_FETCH);
    for (int i = 0; i < 4; i++)  cyc("to_fault", 1'b0, 1'b1, 1'b0, 4'd1, V_HALT | V_FAULT);
    cyc("to_rst", 1'b1, 1'b0, 1'b0, 4'd1, V_IDLE);
    cyc("to_clear", 1'b0, 1'b0, 1'b0, 4'd1, V_FETCH);
`else
    for (int i = 0; i < 24; i++) cyc("no_timeout", 1'b0, 1'b0, 1'b0, 4'd1, V_FETCH);
`endif

    @(negedge Clk);
    #3;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle sequencer for the processor core. It drives instruction fetch, strobes IR_Load into the instruction register, and decodes the latched Opcode. It then issues ALU, register-file, memory and PC control strobes. The instruction register, PC, register file, ALU and RAM are owned by their own modules; this block only schedules them.

Parameters:
OPCODE_WIDTH, 4, width of Opcode input (matches `OPCODE_WIDTH).
ALU_OP_WIDTH, 3, width of Alu_Op output.
TIMEOUT_CYCLES, 16, max wait cycles on a memory handshake (used only with MEM_TIMEOUT_EN).

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Opcode  in  OPCODE_WIDTH  opcode from instruction register (stable while IR_Load low).
Inst_Ready  in  1  RAM: fetched instruction valid on Ram_Inst_Out this cycle.
Data_Ready  in  1  RAM: data read/write completes this cycle.
Inst_Read  out  1  request instruction fetch at PC.
IR_Load  out  1  load instruction register.
PC_Inc  out  1  increment PC.
PC_Load  out  1  load PC from Source_Reg1 (jump).
Alu_Op  out  ALU_OP_WIDTH  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
Reg_Write  out  1  write register file at Dest_Reg.
Wb_Sel  out  2  write-back source: 0 ALU, 1 immediate (Source_Reg1), 2 memory data.
Data_Read  out  1  memory read at address Source_Reg1.
Data_Write  out  1  memory write of Source_Reg2 to address Source_Reg1.
Illegal  out  1  one-cycle pulse on undefined opcode.
Halted  out  1  core halted.
Fault  out  1  memory timeout (MEM_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 LD, 8 ST, 9 JMP, 15 HLT. Values 10-14 are illegal.
- States: FETCH, LOAD, DECODE, EXEC, MEM, WB, HALT. Reset state is FETCH.
- Outputs are Moore-style, decoded from state and Opcode. While Reset=1, every output is 0 and the state goes to FETCH on the edge.
- FETCH: Inst_Read=1. Stays until Inst_Ready=1, then goes to LOAD.
- LOAD: IR_Load=1 and PC_Inc=1 for exactly one cycle, then DECODE.
- DECODE: no strobes. Next state by Opcode:
  - 1-6, 9: EXEC.
  - 7, 8: MEM.
  - 0: FETCH.
  - 15: HALT.
  - illegal: Illegal=1 for this cycle, then FETCH (executes as NOP).
- EXEC, one cycle, then FETCH:
  - ALU ops: Alu_Op=Opcode-1, Reg_Write=1, Wb_Sel=0.
  - LDI: Reg_Write=1, Wb_Sel=1.
  - JMP: PC_Load=1 only.
- MEM: LD holds Data_Read=1; ST holds Data_Write=1. Strobe is held until Data_Ready=1 is sampled. On that cycle LD goes to WB and ST goes to FETCH. Data_Ready outside MEM is ignored.
- WB: Reg_Write=1, Wb_Sel=2 for one cycle, then FETCH.
- HALT: Halted=1, no other strobes. Exit only via Reset.
- Latency with zero-wait memory (Inst_Ready high on the first FETCH cycle):
  - NOP: 3 cycles.
  - ALU/LDI/JMP: 4 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
- Wb_Sel and Alu_Op read 0 when not in use.
- At most one of Inst_Read/Data_Read/Data_Write is high in any cycle.
- Reset during a pending handshake drops the request in the reset cycle; no strobe completes.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle the ready signal is low. When it reaches TIMEOUT_CYCLES without ready, the state goes to HALT and Fault is set (sticky, cleared only by Reset). Halted=1 as well.
- Undefined: no counter; waits are unbounded and Fault is constant 0.

Test Plan:
- Reset held 3 cycles, then released with Inst_Ready=1 and Opcode=1 → Inst_Read high cycle 1, IR_Load/PC_Inc cycle 2, Reg_Write=1 with Alu_Op=0, Wb_Sel=0 cycle 4, Inst_Read again cycle 5.
- Opcode=7 with Data_Ready delayed 3 cycles → Data_Read held 4 cycles, then one WB cycle with Reg_Write=1 and Wb_Sel=2; no Reg_Write before that.
- Opcode=8 then Opcode=9 → Data_Write until Data_Ready with no Reg_Write; then PC_Load=1 for one EXEC cycle and no Reg_Write.
- Opcode=12 → Illegal pulses one cycle in DECODE, no other strobes, back to FETCH. Opcode=15 → Halted=1 held 20 cycles despite Inst_Ready toggling; Reset clears it.
- Reset asserted mid-MEM with Data_Read high → all outputs 0 that cycle; FETCH next; no Reg_Write issued.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, Inst_Ready held 0 → at cycle 16 of FETCH: Fault=1, Halted=1. Without the macro → Inst_Read stays high indefinitely and Fault=0.
